// File: rtl/vm_agent_qdma_demux_axil_regs.sv
// AXI4-Lite slave register file for the QDMA data demux control port (S00_AXI).
//   s00_axi_*  : AXI4-Lite slave, single-beat writes and reads, one outstanding each way
//   cfg_regs   : {reg3, reg2, reg1, reg0} straight from the register flops
//   status_in  : demux status word, snapshotted every cycle (word 4, read-only)
//   evt_pulse  : one-cycle event strobe feeding the saturating counter (word 5, write clears)
// Words 6 and 7 are unmapped and answer SLVERR.
module vm_agent_qdma_demux_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_EVT_CNT_WIDTH    = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in,
  input  logic                            evt_pulse
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned CW = C_EVT_CNT_WIDTH;

  logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;
  logic          aw_held_q, w_held_q;
  logic [2:0]    aw_idx_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] status_q;
  logic [CW-1:0] cnt_q;

  logic          aw_hs, w_hs, ar_hs, wr_commit, cnt_clr;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_strb;
  logic [1:0]    rd_resp;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0]};

  assign aw_hs = awready_q & s00_axi_awvalid;
  assign w_hs  = wready_q & s00_axi_wvalid;
  assign ar_hs = arready_q & s00_axi_arvalid;

  // A half is usable either from its holding register or from this cycle's handshake,
  // so the commit lands on the edge where the late partner is accepted.
  assign wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_idx    = aw_held_q ? aw_idx_q : s00_axi_awaddr[4:2];
  assign wr_data   = w_held_q ? w_data_q : s00_axi_wdata;
  assign wr_strb   = w_held_q ? w_strb_q : s00_axi_wstrb;
  assign cnt_clr   = wr_commit & (wr_idx == 3'd5);
  assign rd_idx    = s00_axi_araddr[4:2];

  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = regs_q[rd_idx[1:0]];
      3'd4:                   rd_data = status_q;
      3'd5:                   rd_data[CW-1:0] = cnt_q;
      default:                rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      status_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      // Ready pulses are withheld while a half is parked or a response is pending.
      awready_q <= s00_axi_awvalid & ~awready_q & ~aw_held_q & ~bvalid_q;
      wready_q  <= s00_axi_wvalid & ~wready_q & ~w_held_q & ~bvalid_q;

      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs)  w_held_q  <= 1'b1;
      end
      if (aw_hs) aw_idx_q <= s00_axi_awaddr[4:2];
      if (w_hs) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end

      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx[2:1] == 2'b11) ? 2'b10 : 2'b00;
      end else if (s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      for (int i = 0; i < 4; i++) begin
        if (wr_commit && wr_idx == 3'(i)) begin
          for (int b = 0; b < int'(SW); b++) begin
            if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end

      arready_q <= s00_axi_arvalid & ~arready_q & ~rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      status_q <= status_in;

      // Clear beats a coincident pulse; otherwise count up and stick at all-ones.
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (evt_pulse && cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign cfg_regs        = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_vm_agent_qdma_demux_axil_regs.sv
// Bench for vm_agent_qdma_demux_axil_regs: directed scenarios plus randomized concurrent
// read/write traffic, checked every cycle against a queue-based reference model.
module tb_vm_agent_qdma_demux_axil_regs;

  localparam int CW = 8;  // narrow counter so saturation is reachable quickly

  logic         clk = 1'b0;
  logic         rstn;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata, status_in;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] cfg_regs;
  logic         evt_pulse;

  always #5 clk = ~clk;

  vm_agent_qdma_demux_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_EVT_CNT_WIDTH   (CW)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rstn),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .cfg_regs       (cfg_regs),
    .status_in      (status_in),
    .evt_pulse      (evt_pulse)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   m_regs [4];
  logic [31:0]   m_status;
  logic [CW-1:0] m_cnt;
  int            aw_q [$];
  logic [31:0]   wd_q [$];
  logic [3:0]    ws_q [$];
  bit            m_bv, m_rv;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_status = '0;
        m_cnt = '0;
        aw_q.delete();
        wd_q.delete();
        ws_q.delete();
        m_bv = 0;
        m_rv = 0;
        m_bresp = '0;
        m_rresp = '0;
        m_rdata = '0;
      end else begin
        int   idx;
        bit   clr;
        logic [31:0] d;
        logic [3:0]  s;
        // Reads see state as it was before this edge.
        if (m_rv && rready) m_rv = 0;
        if (arvalid && arready) begin
          idx = int'(araddr[4:2]);
          m_rv = 1;
          m_rresp = (idx >= 6) ? 2'b10 : 2'b00;
          if (idx < 4)       m_rdata = m_regs[idx];
          else if (idx == 4) m_rdata = m_status;
          else if (idx == 5) m_rdata = 32'(m_cnt);
          else               m_rdata = 32'h0;
        end
        if (m_bv && bready) m_bv = 0;
        if (awvalid && awready) aw_q.push_back(int'(awaddr[4:2]));
        if (wvalid && wready) begin
          wd_q.push_back(wdata);
          ws_q.push_back(wstrb);
        end
        clr = 0;
        if (aw_q.size() > 0 && wd_q.size() > 0) begin
          idx = aw_q.pop_front();
          d = wd_q.pop_front();
          s = ws_q.pop_front();
          if (idx < 4) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
          end
          if (idx == 5) clr = 1;
          m_bv = 1;
          m_bresp = (idx >= 6) ? 2'b10 : 2'b00;
        end
        if (clr) m_cnt = '0;
        else if (evt_pulse && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_status = status_in;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit checking = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && checking) begin
        chk("cfg_regs", cfg_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        chk("bvalid", 128'(bvalid), 128'(m_bv));
        if (m_bv) chk("bresp", 128'(bresp), 128'(m_bresp));
        chk("rvalid", 128'(rvalid), 128'(m_rv));
        if (m_rv) begin
          chk("rdata", 128'(rdata), 128'(m_rdata));
          chk("rresp", 128'(rresp), 128'(m_rresp));
        end
        chk("one_outstanding_aw", 128'(awready && (aw_q.size() != 0 || m_bv)), 128'(0));
        chk("one_outstanding_w", 128'(wready && (wd_q.size() != 0 || m_bv)), 128'(0));
      end
    end
  end

  // ---------------- side-band stimulus ----------------
  int          evt_mode = 0;  // 0 off, 1 random, 2 always on
  bit          st_rand = 0;
  logic [31:0] st_val = '0;
  initial begin
    evt_pulse = 1'b0;
    status_in = '0;
    forever begin
      @(negedge clk);
      #1;
      case (evt_mode)
        1:       evt_pulse = 1'($urandom_range(0, 1));
        2:       evt_pulse = 1'b1;
        default: evt_pulse = 1'b0;
      endcase
      status_in = st_rand ? $urandom : st_val;
    end
  end

  // ---------------- bus tasks (called right after a negedge) ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input bit skip_b, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 100) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      @(posedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    if (evt_mode == 2) evt_mode = 0;
    if (!(aw_done && w_done)) begin
      timeout("write_addr_data");
      return;
    end
    cyc = 0;
    while (!bvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bvalid) begin
      timeout("write_resp");
      return;
    end
    resp = bresp;
    if (skip_b) return;
    repeat (b_dly) @(negedge clk);
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp);
    bit done = 0;
    int cyc = 0;
    d = 'x;
    resp = 'x;
    repeat (ar_dly) @(negedge clk);
    araddr  = a;
    arvalid = 1;
    while (!done && cyc < 100) begin
      @(posedge clk);
      if (arready) done = 1;
      @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    if (!done) begin
      timeout("read_addr");
      return;
    end
    cyc = 0;
    while (!rvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!rvalid) begin
      timeout("read_data");
      return;
    end
    repeat (r_dly) @(negedge clk);
    d = rdata;
    resp = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    rstn = 0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'({awready, wready, arready}), 128'(0));
    chk("reset_valid", 128'({bvalid, rvalid}), 128'(0));
    chk("reset_resp_data", 128'({bresp, rresp, rdata}), 128'(0));
    chk("reset_cfg", cfg_regs, 128'(0));
    #2 rstn = 1;
    @(negedge clk);
    checking = 1;

    // Basic write/readback of the four config words.
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 0, r);
      chk("t1_bresp", 128'(r), 128'(0));
    end
    chk("t1_cfg", cfg_regs, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), 0, 0, d, r);
      chk("t1_rdata", 128'(d), 128'(i + 1));
      chk("t1_rresp", 128'(r), 128'(0));
    end

    // W leads AW by three cycles, partial strobe, slow bready.
    axi_write(5'h04, 32'hDEADBEEF, 4'b0011, 3, 0, 4, 0, r);
    chk("t2_bresp", 128'(r), 128'(0));
    axi_read(5'h04, 0, 0, d, r);
    chk("t2_reg1", 128'(d), 128'h0000BEEF);

    // Unmapped words.
    axi_write(5'h18, 32'h12345678, 4'hF, 0, 1, 0, 0, r);
    chk("t3_bresp", 128'(r), 128'(2));
    chk("t3_cfg", cfg_regs, 128'h00000004_00000003_0000BEEF_00000001);
    axi_read(5'h1C, 0, 2, d, r);
    chk("t3_rresp", 128'(r), 128'(2));
    chk("t3_rdata", 128'(d), 128'(0));

    // Event counter: count, clear-wins, saturate.
    evt_mode = 2;
    repeat (5) @(negedge clk);
    evt_mode = 0;
    repeat (2) @(negedge clk);
    axi_read(5'h14, 0, 0, d, r);
    chk("t4_cnt5", 128'(d), 128'(5));
    evt_mode = 2;
    axi_write(5'h14, 32'h0, 4'h0, 0, 0, 0, 0, r);
    chk("t4_clr_bresp", 128'(r), 128'(0));
    axi_read(5'h14, 0, 0, d, r);
    chk("t4_clr_wins", 128'(d), 128'(0));
    evt_mode = 2;
    repeat (300) @(negedge clk);
    evt_mode = 0;
    repeat (2) @(negedge clk);
    axi_read(5'h14, 0, 0, d, r);
    chk("t4_saturate", 128'(d), 128'h000000FF);

    // Status snapshot, read-only.
    st_val = 32'hA5A50001;
    repeat (3) @(negedge clk);
    axi_read(5'h10, 0, 0, d, r);
    chk("t5_status", 128'(d), 128'hA5A50001);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, r);
    chk("t5_bresp", 128'(r), 128'(0));
    axi_read(5'h13, 0, 0, d, r);
    chk("t5_status_kept", 128'(d), 128'hA5A50001);

    // Reset while a write response is pending.
    axi_write(5'h00, 32'h00000077, 4'hF, 0, 0, 0, 1, r);
    chk("t6_pre_bvalid", 128'(bvalid), 128'(1));
    #2 rstn = 0;
    #1;
    chk("t6_bvalid_drop", 128'(bvalid), 128'(0));
    chk("t6_cfg_clear", cfg_regs, 128'(0));
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    bready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_stale_b", 128'(bvalid), 128'(0));
    end
    bready = 0;
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), 0, 0, d, r);
      chk("t6_reg_zero", 128'(d), 128'(0));
    end

    // Randomized concurrent traffic, model-checked every cycle.
    evt_mode = 1;
    st_rand = 1;
    fork
      begin
        logic [1:0] wr_r;
        for (int n = 0; n < 80; n++) begin
          axi_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    0, wr_r);
        end
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        for (int n = 0; n < 80; n++) begin
          axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 3),
                   rd_d, rd_r);
        end
      end
    join
    evt_mode = 0;
    st_rand = 0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vm_agent_qdma_demux_axil_regs.md
Name: vm_agent_qdma_demux_axil_regs

Overview:
AXI4-Lite slave register file that answers the S00_AXI control port of the QDMA data demux. It terminates master-issued single-beat writes and reads and drives static configuration words into the demux datapath. It also exposes a sampled status word and a clearable event counter. It is the responder for the AXI4-Lite master traffic used to configure and read back the demux.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width, giving an 8-word register space.
C_EVT_CNT_WIDTH, 32, event counter width, at most C_S_AXI_DATA_WIDTH.

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
cfg_regs  out  128  {reg3,reg2,reg1,reg0}, driven straight from the register flops
status_in  in  32  demux status word
evt_pulse  in  1  one-cycle event strobe

Behaviour:
- Reset (asynchronous on the falling edge of aresetn, released synchronously to the clock): all ready and valid outputs are 0, bresp and rresp are 0, rdata is 0, reg0 to reg3 are 0, the counter is 0 and the status snapshot is 0. If reset asserts mid-transaction, the transaction is abandoned and no response is issued.
- Register map, using word index = addr[4:2] (addr[1:0] is ignored):
  - 0 to 3: read/write.
  - 4: read-only status snapshot, registered from status_in every cycle.
  - 5: event counter; a write of any value clears it.
  - 6 and 7: unmapped.
- Write path:
  - AW and W are accepted independently, with awready and wready each a one-cycle pulse.
  - Either channel may arrive first. The accepted address or data is held until its partner arrives, and no further AW or W is accepted until the B handshake completes (one outstanding write).
  - Commit happens on the cycle both halves are held. Each byte lane is written where its wstrb bit is 1.
  - bvalid asserts on the cycle after commit and stays high until bready; awready and wready are then allowed again the next cycle.
  - bresp is OKAY (00) for indices 0 to 5 (a write to 4 is silently ignored) and SLVERR (10) for indices 6 and 7, with no state change.
- Read path:
  - arready pulses for one cycle when arvalid=1 and no read is outstanding.
  - rvalid and rdata are registered on the next cycle, so latency from AR handshake to rvalid is 1 cycle.
  - rdata is held stable until rready.
  - rresp is SLVERR with rdata=0 for indices 6 and 7.
- Read and write paths are fully independent. If a read and a write to the same word are accepted in the same cycle, the read returns the pre-write value.
- Event counter:
  - Increments on evt_pulse and saturates at all-ones.
  - A clear commit and evt_pulse in the same cycle give 0; clear wins and the pulse is dropped.
  - A read concurrent with an increment returns the pre-increment value.
- cfg_regs updates on the cycle after the commit edge, i.e. visible with bvalid.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> every bresp and rresp=00, rdata matches, cfg_regs=0x00000004_00000003_00000002_00000001.
2. W presented 3 cycles before AW, to 0x04 with data 0xDEADBEEF and wstrb=0011 over prior 0x00000002 -> commit only when AW arrives; reg1=0x0000BEEF; bvalid held for 4 cycles until bready.
3. Write 0x18 and read 0x1C -> bresp=10 with no register change; rresp=10 and rdata=0.
4. Pulse evt_pulse 5 times, read 0x14 -> 5. Write 0x14 in the same cycle as an evt_pulse -> counter=0. Force the count to 0xFFFFFFFF plus one pulse -> stays 0xFFFFFFFF.
5. Drive status_in=0xA5A5_0001, read 0x10 -> rdata=0xA5A50001. Write 0x10 -> bresp=00 and the value is unchanged.
6. Drop aresetn while bvalid is pending -> bvalid goes to 0 immediately; after release, reg0 to reg3 read 0 and no stale B is issued.
